// File: rtl/prng_reader.sv
// rtl/prng_reader.sv - PRNG requester: pulls serial random bits, assembles WIDTH-bit words, hands them out valid/ready.
// Optional read timeout with sticky rd_err is enabled by defining PRNG_READER_TIMEOUT_EN.
module prng_reader #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req,
   input  logic             rnd_bit,
   input  logic             rnd_valid,
   output logic             get_random,
   output logic             data_done,
   output logic [WIDTH-1:0] rand_word,
   output logic             rand_valid,
   input  logic             rand_ready,
   output logic             rd_err
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_COLLECT = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-2:0] shift_q;
   logic [WIDTH-1:0] shift_nx;
   logic             last_bit;
   logic             busy;
   logic             timeout_hit;

   // shift_q keeps only the WIDTH-1 bits captured so far; the newest bit completes the word
   assign shift_nx = {shift_q, rnd_bit};
   assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
   assign busy     = (state == S_REQ) || (state == S_COLLECT);

`ifdef PRNG_READER_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_cnt;

   assign timeout_hit = busy && !rnd_valid && (wait_cnt == WAIT_W'(TIMEOUT - 1));

   // Cleared outside REQ/COLLECT, so every entry into REQ starts a fresh wait window
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt <= '0;
      end else if (!busy || rnd_valid || timeout_hit) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_err <= 1'b0;
      end else if (timeout_hit) begin
         rd_err <= 1'b1;
      end
   end
`else
   localparam logic unused_timeout = (TIMEOUT > 0);

   assign timeout_hit = 1'b0;
   assign rd_err      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shift_q    <= '0;
         get_random <= 1'b0;
         data_done  <= 1'b0;
         rand_word  <= '0;
         rand_valid <= 1'b0;
      end else begin
         data_done <= 1'b0;
         case (state)
            S_IDLE: begin
               get_random <= 1'b0;
               if (req) begin
                  state      <= S_REQ;
                  get_random <= 1'b1;
               end
            end

            S_REQ: begin
               if (rnd_valid) begin
                  shift_q    <= shift_nx[WIDTH-2:0];
                  bit_cnt    <= CNT_W'(1);
                  get_random <= 1'b0;
                  state      <= S_COLLECT;
               end else if (timeout_hit) begin
                  shift_q    <= '0;
                  bit_cnt    <= '0;
                  get_random <= 1'b0;
                  state      <= S_IDLE;
               end
            end

            S_COLLECT: begin
               if (rnd_valid) begin
                  if (last_bit) begin
                     // shift_q is cleared here so a later word never sees stale bits
                     rand_word  <= shift_nx;
                     rand_valid <= 1'b1;
                     data_done  <= 1'b1;
                     bit_cnt    <= '0;
                     shift_q    <= '0;
                     state      <= S_HOLD;
                  end else begin
                     shift_q <= shift_nx[WIDTH-2:0];
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else if (timeout_hit) begin
                  shift_q <= '0;
                  bit_cnt <= '0;
                  state   <= S_IDLE;
               end
            end

            S_HOLD: begin
               if (rand_ready) begin
                  rand_valid <= 1'b0;
                  if (req) begin
                     state      <= S_REQ;
                     get_random <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            default: begin
               state      <= S_IDLE;
               bit_cnt    <= '0;
               shift_q    <= '0;
               get_random <= 1'b0;
               rand_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prng_reader.sv
// tb/tb_prng_reader.sv - scoreboard bench for prng_reader (timeout cases need PRNG_READER_TIMEOUT_EN).
module tb_prng_reader;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       req = 1'b0;
   logic       rnd_bit = 1'b0;
   logic       rnd_valid = 1'b0;
   logic       rand_ready = 1'b0;
   logic       get_random;
   logic       data_done;
   logic [7:0] rand_word;
   logic       rand_valid;
   logic       rd_err;

   int         total = 0;
   int         bad = 0;
   int         dd_cnt = 0;
   int         n_words = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   prng_reader #(.WIDTH(8), .CNT_W(4), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .rnd_bit    (rnd_bit),
      .rnd_valid  (rnd_valid),
      .get_random (get_random),
      .data_done  (data_done),
      .rand_word  (rand_word),
      .rand_valid (rand_valid),
      .rand_ready (rand_ready),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Every data_done pulse retires the oldest expected word
   always @(negedge clk) begin
      if (rstn && data_done) begin
         dd_cnt++;
         if (exp_q.size() == 0) begin
            chk("dd_spurious", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("word", {24'd0, rand_word}, {24'd0, mon_exp});
            chk("valid_at_done", {31'd0, rand_valid}, 32'd1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_get();
      int n;
      n = 0;
      while (!get_random && n < 20) begin
         tick();
         n++;
      end
      chk("get_random_rise", {31'd0, get_random}, 32'd1);
   endtask

   task automatic send_word(input logic [7:0] w, input int gap, input logic req_after);
      logic early;
      early = 1'b0;
      exp_q.push_back(w);
      n_words++;
      wait_get();
      req = req_after;
      for (int i = 0; i < 8; i++) begin
         rnd_valid = 1'b1;
         rnd_bit   = w[7-i];
         tick();
         if (i == 0) chk("get_random_drop", {31'd0, get_random}, 32'd0);
         if (i < 7) begin
            early = early | data_done;
            if ((i == 2 || i == 5) && gap > 0) begin
               rnd_valid = 1'b0;
               rnd_bit   = ~w[7-i];
               repeat (gap) begin
                  tick();
                  early = early | data_done;
               end
            end
         end
      end
      rnd_valid = 1'b0;
      chk("no_early_done", {31'd0, early}, 32'd0);
      chk("done_pulse", {31'd0, data_done}, 32'd1);
      chk("rand_valid_rise", {31'd0, rand_valid}, 32'd1);
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_get_random", {31'd0, get_random}, 32'd0);
      chk("rst_data_done", {31'd0, data_done}, 32'd0);
      chk("rst_rand_word", {24'd0, rand_word}, 32'd0);
      chk("rst_rand_valid", {31'd0, rand_valid}, 32'd0);
      chk("rst_rd_err", {31'd0, rd_err}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      // basic word, consumer ready, req dropped mid-word
      rand_ready = 1'b1;
      req = 1'b1;
      send_word(8'hA5, 0, 1'b0);
      tick();
      chk("basic_done_once", {31'd0, data_done}, 32'd0);
      chk("basic_idle_valid", {31'd0, rand_valid}, 32'd0);
      chk("basic_idle_get", {31'd0, get_random}, 32'd0);

      // gapped stream, bits driven inverted during gaps
      req = 1'b1;
      send_word(8'hA5, 2, 1'b0);
      tick();
      chk("gap_done_once", {31'd0, data_done}, 32'd0);

      // backpressure then back-to-back request
      rand_ready = 1'b0;
      req = 1'b1;
      send_word(8'hC3, 0, 1'b0);
      repeat (5) begin
         tick();
         chk("bp_valid", {31'd0, rand_valid}, 32'd1);
         chk("bp_word", {24'd0, rand_word}, 32'h0000_00C3);
         chk("bp_done_once", {31'd0, data_done}, 32'd0);
      end
      req = 1'b1;
      rand_ready = 1'b1;
      tick();
      chk("b2b_get_random", {31'd0, get_random}, 32'd1);
      chk("b2b_valid_drop", {31'd0, rand_valid}, 32'd0);
      rand_ready = 1'b0;
      send_word(8'h3C, 0, 1'b0);

      // rnd_valid ignored while holding
      for (int i = 0; i < 4; i++) begin
         rnd_valid = 1'b1;
         rnd_bit = i[0];
         tick();
      end
      rnd_valid = 1'b0;
      chk("hold_ign_word", {24'd0, rand_word}, 32'h0000_003C);
      chk("hold_ign_valid", {31'd0, rand_valid}, 32'd1);
      chk("hold_ign_done", {31'd0, data_done}, 32'd0);
      rand_ready = 1'b1;
      req = 1'b0;
      tick();

      // rnd_valid ignored while idle
      for (int i = 0; i < 3; i++) begin
         rnd_valid = 1'b1;
         rnd_bit = 1'b1;
         tick();
      end
      rnd_valid = 1'b0;
      chk("idle_ign_get", {31'd0, get_random}, 32'd0);
      chk("idle_ign_word", {24'd0, rand_word}, 32'h0000_003C);
      chk("idle_ign_valid", {31'd0, rand_valid}, 32'd0);
      req = 1'b1;
      send_word(8'h96, 0, 1'b0);
      tick();

      // reset in the middle of a word
      req = 1'b1;
      wait_get();
      for (int i = 0; i < 3; i++) begin
         rnd_valid = 1'b1;
         rnd_bit = 1'b1;
         tick();
      end
      rnd_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_get", {31'd0, get_random}, 32'd0);
      chk("mid_rst_word", {24'd0, rand_word}, 32'd0);
      chk("mid_rst_valid", {31'd0, rand_valid}, 32'd0);
      chk("mid_rst_done", {31'd0, data_done}, 32'd0);
      chk("mid_rst_err", {31'd0, rd_err}, 32'd0);
      req = 1'b0;
      tick();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      req = 1'b1;
      send_word(8'hFF, 0, 1'b0);
      tick();

`ifdef PRNG_READER_TIMEOUT_EN
      req = 1'b1;
      wait_get();
      req = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("to_wait_err", {31'd0, rd_err}, 32'd0);
         chk("to_wait_get", {31'd0, get_random}, 32'd1);
      end
      tick();
      chk("to_err", {31'd0, rd_err}, 32'd1);
      chk("to_get_drop", {31'd0, get_random}, 32'd0);
      chk("to_valid", {31'd0, rand_valid}, 32'd0);
      repeat (3) tick();
      chk("to_err_sticky", {31'd0, rd_err}, 32'd1);
      chk("to_idle_get", {31'd0, get_random}, 32'd0);
`else
      req = 1'b1;
      wait_get();
      req = 1'b0;
      repeat (20) tick();
      chk("no_to_get", {31'd0, get_random}, 32'd1);
      chk("no_to_err", {31'd0, rd_err}, 32'd0);
      send_word(8'h81, 0, 1'b0);
      tick();
`endif

      repeat (2) tick();
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("dd_count", dd_cnt, n_words);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prng_reader.md
Name: prng_reader

Overview:
- Requester/consumer side of the PRNG handshake.
- Asserts get_random to pull the generator into its data-output phase, then deserializes the serial random bit stream into a WIDTH-bit word.
- Returns data_done to release the generator back to shifting.
- Presents the assembled word to downstream logic over a valid/ready interface. Sits between the PRNG core and any block that consumes random words.

Parameters:
- WIDTH, 8, bits per random word (≥2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W ≥ WIDTH.
- TIMEOUT, 16, max idle cycles waiting for rnd_valid (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  1  level request for a new random word from the consumer
- rnd_bit  in  1  serial random bit from the PRNG
- rnd_valid  in  1  rnd_bit qualifier, high while the PRNG is outputting data
- get_random  out  1  request to the PRNG to enter its data-output state
- data_done  out  1  one-cycle pulse: word fully received, PRNG may resume shifting
- rand_word  out  WIDTH  assembled random word
- rand_valid  out  1  rand_word valid
- rand_ready  in  1  consumer accepts rand_word
- rd_err  out  1  sticky timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rstn.
- Reset values: all outputs 0, state IDLE, bit counter 0, shift register 0. Reset mid-operation aborts immediately; a partial word is discarded, with no data_done pulse.
- All outputs are registered.
- States:
  - IDLE: get_random=0. When req=1, go to REQ.
  - REQ: get_random=1. On the first rnd_valid=1, capture that bit (counter ← 1) and go to COLLECT. get_random drops in the cycle COLLECT is entered.
  - COLLECT: get_random=0. On each rnd_valid=1, shift MSB-first: word ← {word[WIDTH-2:0], rnd_bit}, counter+1. rnd_valid=0 cycles are gaps: hold, no shift. When the WIDTH-th bit is captured, go to HOLD.
  - HOLD: rand_valid=1; rand_word is stable and equals the captured word.
    - rand_ready=1 and req=1: go to REQ (back-to-back, no IDLE cycle).
    - rand_ready=1 and req=0: go to IDLE.
    - rand_ready=0: stay in HOLD indefinitely.
- data_done:
  - High exactly one cycle, the cycle after the WIDTH-th bit is sampled, coincident with the first HOLD cycle.
  - rand_valid rises in the same cycle.
  - Never asserted otherwise.
- rnd_valid in IDLE or HOLD is ignored: no shift, no counter change.
- req deasserting in REQ or COLLECT does not abort; the word completes.
- Latency: first rnd_valid sample to rand_valid = WIDTH cycles with no gaps.
- Counter resets to 0 on entering HOLD. No wrap beyond WIDTH.
- rand_word updates only on the transition into HOLD. Internal shifting is invisible on rand_word until the word is complete.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro: PRNG_READER_TIMEOUT_EN.
- Defined:
  - A wait counter runs in REQ and COLLECT; it clears on every rnd_valid=1 and on state entry.
  - If it reaches TIMEOUT with no rnd_valid, set rd_err=1 (sticky until reset), discard the partial word, go to IDLE without data_done, and drop get_random.
- Undefined: no wait counter; rd_err tied 0; REQ/COLLECT wait indefinitely.

Test Plan:
- Basic word: reset, req=1, after get_random drive rnd_valid=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 → rand_word=8'hA5, rand_valid=1 and one-cycle data_done in the cycle after the 8th bit.
- Gapped stream: same bits with rnd_valid low for 2 cycles between bits 3–4 and 6–7 → rand_word=8'hA5, data_done delayed by 4 cycles; no shift during gaps.
- Backpressure and back-to-back:
  - Hold rand_ready=0 for 5 cycles → rand_word/rand_valid stable, data_done pulsed once only.
  - Then rand_ready=1 with req=1 → get_random=1 next cycle; second stream 8'h3C is captured correctly.
- Ignored data: pulse rnd_valid with bits while in IDLE and in HOLD → rand_word unchanged, counter unaffected.
- Reset mid-collect: deassert rstn after 3 bits → all outputs 0 immediately. Post-reset, a fresh stream 8'hFF yields 8'hFF, with no residue from the aborted word.
- Timeout (PRNG_READER_TIMEOUT_EN, TIMEOUT=16): req=1, never drive rnd_valid → after 16 cycles in REQ, rd_err=1, get_random=0, state IDLE, data_done never asserted.
